// File: rtl/spi_reg_slave.sv
// SPI register-file slave: 8-bit command word (R/nW + start address) then auto-incrementing data words.
// Optional build macro SPI_REG_STATUS_EN maps the top address to a read-only i_Status input.
module spi_reg_slave #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                             w_SPI_Clk,
    input  logic                             i_Rst_L,
    input  logic                             i_SPI_CS_n,
    input  logic                             i_SPI_MOSI,
    output logic                             o_SPI_MISO,
    output logic [(2**ADDR_W)*DATA_W-1:0]    o_Regs,
    output logic                             o_Wr_Strobe,
    output logic [ADDR_W-1:0]                o_Wr_Addr
`ifdef SPI_REG_STATUS_EN
    ,
    input  logic [DATA_W-1:0]                i_Status
`endif
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int CNT_W = (DATA_W > 8) ? $clog2(DATA_W) : 3;
`ifdef SPI_REG_STATUS_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH-1);
`endif

    typedef enum logic [1:0] {ST_CMD, ST_WR_DATA, ST_RD_DATA} state_t;

    state_t              state_reg;
    logic [CNT_W-1:0]    bit_cnt_reg;
    logic                wr_strobe_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [ADDR_W-1:0]   wr_addr_reg;
    logic [6:0]          cmd_sr_reg;
    logic [DATA_W-2:0]   data_sr_reg;
    logic [DATA_W-1:0]   tx_sr_reg;
    logic [DATA_W-1:0]   regs_reg [DEPTH];

    logic                cmd_last;
    logic                word_last;
    logic                cmd_rw;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [ADDR_W-1:0]   addr_inc;
    logic [DATA_W-1:0]   data_word;
    logic                wr_drop;
    logic                wr_en;

    // Read path: the status word shadows the top register when enabled.
    function automatic logic [DATA_W-1:0] rd_word(input logic [ADDR_W-1:0] a);
`ifdef SPI_REG_STATUS_EN
        if (a == LAST_ADDR)
            return i_Status;
`endif
        return regs_reg[a];
    endfunction

    always_comb begin
        cmd_last  = (state_reg == ST_CMD) && (bit_cnt_reg == CNT_W'(7));
        word_last = (bit_cnt_reg == CNT_W'(DATA_W-1));
        addr_inc  = addr_reg + 1'b1;
        // Assembled words include the bit being sampled on this edge.
        if (MSB_FIRST != 0) begin
            cmd_rw    = cmd_sr_reg[6];
            cmd_addr  = ADDR_W'({cmd_sr_reg, i_SPI_MOSI});
            data_word = {data_sr_reg, i_SPI_MOSI};
        end else begin
            cmd_rw    = i_SPI_MOSI;
            cmd_addr  = cmd_sr_reg[ADDR_W-1:0];
            data_word = {i_SPI_MOSI, data_sr_reg};
        end
`ifdef SPI_REG_STATUS_EN
        wr_drop = (addr_reg == LAST_ADDR);
`else
        wr_drop = 1'b0;
`endif
        wr_en = !i_SPI_CS_n && (state_reg == ST_WR_DATA) && word_last && !wr_drop;
    end

    // Frame control: chip-select high clears it asynchronously, exactly like reset.
    always_ff @(posedge w_SPI_Clk or negedge i_Rst_L or posedge i_SPI_CS_n) begin
        if (!i_Rst_L || i_SPI_CS_n) begin
            state_reg     <= ST_CMD;
            bit_cnt_reg   <= '0;
            wr_strobe_reg <= 1'b0;
        end else begin
            wr_strobe_reg <= 1'b0;
            case (state_reg)
                ST_CMD: begin
                    if (cmd_last) begin
                        bit_cnt_reg <= '0;
                        state_reg   <= cmd_rw ? ST_RD_DATA : ST_WR_DATA;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    end
                end
                ST_WR_DATA: begin
                    if (word_last) begin
                        bit_cnt_reg   <= '0;
                        wr_strobe_reg <= !wr_drop;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    end
                end
                ST_RD_DATA: begin
                    if (word_last)
                        bit_cnt_reg <= '0;
                    else
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                end
                default: begin
                    state_reg   <= ST_CMD;
                    bit_cnt_reg <= '0;
                end
            endcase
        end
    end

    // Datapath survives a chip-select abort; it is simply not advanced while deselected.
    always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            addr_reg    <= '0;
            cmd_sr_reg  <= '0;
            data_sr_reg <= '0;
            tx_sr_reg   <= '0;
        end else if (!i_SPI_CS_n) begin
            if (MSB_FIRST != 0) begin
                cmd_sr_reg  <= 7'({cmd_sr_reg, i_SPI_MOSI});
                data_sr_reg <= (DATA_W-1)'({data_sr_reg, i_SPI_MOSI});
            end else begin
                cmd_sr_reg  <= 7'({i_SPI_MOSI, cmd_sr_reg} >> 1);
                data_sr_reg <= (DATA_W-1)'({i_SPI_MOSI, data_sr_reg} >> 1);
            end
            case (state_reg)
                ST_CMD: begin
                    if (cmd_last) begin
                        addr_reg <= cmd_addr;
                        if (cmd_rw)
                            tx_sr_reg <= rd_word(cmd_addr);
                    end
                end
                ST_WR_DATA: begin
                    if (word_last)
                        addr_reg <= addr_inc;
                end
                ST_RD_DATA: begin
                    // Preload the next word on the last bit so bursts stream without a gap.
                    if (word_last) begin
                        addr_reg  <= addr_inc;
                        tx_sr_reg <= rd_word(addr_inc);
                    end else if (MSB_FIRST != 0) begin
                        tx_sr_reg <= tx_sr_reg << 1;
                    end else begin
                        tx_sr_reg <= tx_sr_reg >> 1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            for (int k = 0; k < DEPTH; k++)
                regs_reg[k] <= '0;
            wr_addr_reg <= '0;
        end else if (wr_en) begin
            regs_reg[addr_reg] <= data_word;
            wr_addr_reg        <= addr_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_regs_out
`ifdef SPI_REG_STATUS_EN
            if (gi == DEPTH-1) begin : g_status_slot
                assign o_Regs[gi*DATA_W +: DATA_W] = '0;
            end else begin : g_plain_slot
                assign o_Regs[gi*DATA_W +: DATA_W] = regs_reg[gi];
            end
`else
            assign o_Regs[gi*DATA_W +: DATA_W] = regs_reg[gi];
`endif
        end
    endgenerate

    assign o_SPI_MISO  = (state_reg == ST_RD_DATA) && !i_SPI_CS_n &&
                         ((MSB_FIRST != 0) ? tx_sr_reg[DATA_W-1] : tx_sr_reg[0]);
    assign o_Wr_Strobe = wr_strobe_reg;
    assign o_Wr_Addr   = wr_addr_reg;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Bench for spi_reg_slave: default 8-bit MSB-first instance plus a 12-bit LSB-first instance.
module tb_spi_reg_slave;

`ifdef SPI_REG_STATUS_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cs_n;
    logic          mosi;
    logic          miso_a, miso_b;
    logic [127:0]  regs_a;
    logic [191:0]  regs_b;
    logic          strb_a, strb_b;
    logic [3:0]    wa_a, wa_b;
    logic [7:0]    status_a;
    logic [11:0]   status_b;

    int n_cmp  = 0;
    int n_fail = 0;
    int strb_cnt_a = 0;
    int strb_cnt_b = 0;

    logic [7:0] rd_q[$];
    logic       bit_q[$];

    typedef struct {
        bit          rd;
        logic [3:0]  addr;
        int          n;
        logic [31:0] wdata;
        logic [31:0] rexp;
    } row_t;

    row_t rows[8];

    always #5 clk = ~clk;

    spi_reg_slave #(.DATA_W(8), .ADDR_W(4), .MSB_FIRST(1)) u_dut_a (
        .w_SPI_Clk  (clk),
        .i_Rst_L    (rst_n),
        .i_SPI_CS_n (cs_n),
        .i_SPI_MOSI (mosi),
        .o_SPI_MISO (miso_a),
        .o_Regs     (regs_a),
        .o_Wr_Strobe(strb_a),
        .o_Wr_Addr  (wa_a)
`ifdef SPI_REG_STATUS_EN
        ,
        .i_Status   (status_a)
`endif
    );

    spi_reg_slave #(.DATA_W(12), .ADDR_W(4), .MSB_FIRST(0)) u_dut_b (
        .w_SPI_Clk  (clk),
        .i_Rst_L    (rst_n),
        .i_SPI_CS_n (cs_n),
        .i_SPI_MOSI (mosi),
        .o_SPI_MISO (miso_b),
        .o_Regs     (regs_b),
        .o_Wr_Strobe(strb_b),
        .o_Wr_Addr  (wa_b)
`ifdef SPI_REG_STATUS_EN
        ,
        .i_Status   (status_b)
`endif
    );

    always @(negedge clk) begin
        if (strb_a) strb_cnt_a++;
        if (strb_b) strb_cnt_b++;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge; presents nb bits and samples MISO before each rising edge.
    task automatic xfer(input logic [31:0] w, input int nb, input bit msb, input bit sel_b,
                        output logic [31:0] rx);
        int idx;
        rx = '0;
        for (int i = 0; i < nb; i++) begin
            idx     = msb ? nb - 1 - i : i;
            mosi    = w[idx];
            rx[idx] = sel_b ? miso_b : miso_a;
            @(negedge clk);
        end
    endtask

    task automatic run_row(input int id, input row_t r);
        logic [31:0] rx;
        logic [3:0]  a;
        logic [7:0]  wv;
        logic        exp_s;
        if (r.rd)
            for (int i = 0; i < r.n; i++) rd_q.push_back(r.rexp[i*8 +: 8]);
        @(negedge clk);
        cs_n = 1'b0;
        xfer({24'h0, r.rd, 3'b000, r.addr}, 8, 1'b1, 1'b0, rx);
        check("miso_in_cmd", rx, 32'h0);
        a = r.addr;
        for (int i = 0; i < r.n; i++) begin
            if (r.rd) begin
                xfer($urandom, 8, 1'b1, 1'b0, rx);
                check("rd_word", rx, {24'h0, rd_q.pop_front()});
            end else begin
                wv = r.wdata[i*8 +: 8];
                xfer({24'h0, wv}, 8, 1'b1, 1'b0, rx);
                check("miso_in_wr", rx, 32'h0);
                exp_s = !(STAT && a == 4'd15);
                check("wr_strobe", {31'h0, strb_a}, {31'h0, exp_s});
                if (exp_s) check("wr_addr", {28'h0, wa_a}, {28'h0, a});
                check("wr_reg", {24'h0, regs_a[int'(a)*8 +: 8]}, exp_s ? {24'h0, wv} : 32'h0);
            end
            a = a + 4'd1;
        end
        cs_n = 1'b1;
        repeat (2) @(negedge clk);
        $display("row %0d: %s addr=%0d words=%0d done", id, r.rd ? "read" : "write", r.addr, r.n);
    endtask

    initial begin : main
        logic [31:0] rx;
        logic [11:0] seq;
        logic        m;
        int          c0;

        rows[0] = '{1'b1, 4'd0,  4, 32'h0,        32'h0};
        rows[1] = '{1'b0, 4'd3,  2, 32'h00005AA5, 32'h0};
        rows[2] = '{1'b1, 4'd3,  2, 32'h0,        32'h00005AA5};
        rows[3] = '{1'b0, 4'd15, 3, 32'h003322FF, 32'h0};
        rows[4] = '{1'b1, 4'd15, 3, 32'h0,        STAT ? 32'h0033223C : 32'h003322FF};
        rows[5] = '{1'b1, 4'd2,  3, 32'h0,        32'h005AA500};
        rows[6] = '{1'b0, 4'd7,  1, 32'h000000C3, 32'h0};
        rows[7] = '{1'b1, 4'd6,  3, 32'h0,        32'h0000C300};

        status_a = 8'h3C;
        status_b = 12'h3C;
        rst_n = 1'b0;
        cs_n  = 1'b1;
        mosi  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_regs_a", {31'h0, regs_a == '0}, 32'h1);
        check("rst_strobe", {31'h0, strb_a}, 32'h0);
        check("rst_wr_addr", {28'h0, wa_a}, 32'h0);
        check("rst_miso", {31'h0, miso_a}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int r = 0; r < 8; r++) run_row(r, rows[r]);

        // Partial write aborted by chip select: nothing committed, next frame decodes cleanly.
        c0 = strb_cnt_a;
        @(negedge clk);
        cs_n = 1'b0;
        xfer(32'h02, 8, 1'b1, 1'b0, rx);
        xfer(32'h1F, 5, 1'b1, 1'b0, rx);
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_reg2", {24'h0, regs_a[16 +: 8]}, 32'h0);
        check("abort_strobe", c0 - strb_cnt_a, 32'h0);
        $display("abort frame: strobes=%0d reg2=%h", strb_cnt_a - c0, regs_a[16 +: 8]);
        run_row(8, '{1'b1, 4'd3, 2, 32'h0, 32'h00005AA5});

        // 12-bit LSB-first instance: write 0x9C3 to address 1, read back bit by bit.
        seq = 12'h9C3;
        @(negedge clk);
        cs_n = 1'b0;
        xfer(32'h01, 8, 1'b0, 1'b1, rx);
        xfer({20'h0, seq}, 12, 1'b0, 1'b1, rx);
        check("b_strobe", {31'h0, strb_b}, 32'h1);
        check("b_wr_addr", {28'h0, wa_b}, 32'h1);
        check("b_reg1", {20'h0, regs_b[12 +: 12]}, {20'h0, seq});
        cs_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 12; i++) bit_q.push_back(seq[i]);
        @(negedge clk);
        cs_n = 1'b0;
        xfer(32'h81, 8, 1'b0, 1'b1, rx);
        for (int i = 0; i < 12; i++) begin
            mosi = 1'($urandom);
            m = miso_b;
            @(negedge clk);
            check("b_miso_bit", {31'h0, m}, {31'h0, bit_q.pop_front()});
        end
        cs_n = 1'b1;
        repeat (2) @(negedge clk);
        $display("dut_b: 12-bit LSB-first write/read of %h done", seq);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
